// File: rtl/lut_expr_eval.sv
// lut_expr_eval: run-time programmable N_IN-input Boolean function.
// A truth table of 2**N_IN entries is shifted in serially, index 0 first.
// Once the table is complete, each valid input vector is looked up with
// one cycle of latency. Full throughput is one result per cycle.
module lut_expr_eval #(
    parameter int N_IN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_start,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    output logic            cfg_busy,
    output logic            cfg_done,
    input  logic            in_valid,
    input  logic [N_IN-1:0] in_vec,
    output logic            out_valid,
    output logic            y,
    output logic [N_IN:0]   ones_count,
    output logic            loaded
);
    localparam int DEPTH = 1 << N_IN;

    typedef enum logic [1:0] {
        EMPTY,
        LOAD,
        RUN
    } state_t;

    state_t           state;
    logic [DEPTH-1:0] tbl;
    logic [N_IN-1:0]  idx;
    logic [N_IN:0]    run_cnt;
    logic [N_IN:0]    cnt_next;
    logic             last_entry;

    // The running count is one bit wider than idx, so an all-ones table
    // reports 2**N_IN and does not wrap to zero.
    assign cnt_next   = run_cnt + {{N_IN{1'b0}}, cfg_bit};
    assign last_entry = (idx == {N_IN{1'b1}});

    // Control FSM, table write port and registered lookup result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            tbl        <= '0;
            idx        <= '0;
            run_cnt    <= '0;
            cfg_busy   <= 1'b0;
            cfg_done   <= 1'b0;
            out_valid  <= 1'b0;
            y          <= 1'b0;
            ones_count <= '0;
            loaded     <= 1'b0;
        end else begin
            cfg_done  <= 1'b0;
            out_valid <= 1'b0;
            if (cfg_start) begin
                // A start from any state, including mid-load, rewinds to
                // entry 0. A cfg_valid in this cycle is deliberately dropped.
                // Old entries remain until overwritten, and ones_count keeps
                // the previous table's value until the new load completes.
                state    <= LOAD;
                idx      <= '0;
                run_cnt  <= '0;
                loaded   <= 1'b0;
                cfg_busy <= 1'b1;
            end else begin
                case (state)
                    LOAD: begin
                        if (cfg_valid) begin
                            tbl[idx] <= cfg_bit;
                            run_cnt  <= cnt_next;
                            if (last_entry) begin
                                state      <= RUN;
                                idx        <= '0;
                                cfg_busy   <= 1'b0;
                                cfg_done   <= 1'b1;
                                ones_count <= cnt_next;
                                loaded     <= 1'b1;
                            end else begin
                                idx <= idx + N_IN'(1);
                            end
                        end
                    end
                    RUN: begin
                        // y holds its value whenever there is no valid input.
                        if (in_valid) begin
                            y         <= tbl[in_vec];
                            out_valid <= 1'b1;
                        end
                    end
                    default: begin
                        // EMPTY: inputs are ignored until a load begins.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lut_expr_eval.sv
// Bench for lut_expr_eval: one 4-input and one 6-input instance.
// Expected lookup results are queued when inputs are driven, then popped
// when out_valid appears.
module tb_lut_expr_eval;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;

    // 4-input instance signals
    logic       cfg_start4, cfg_valid4, cfg_bit4, in_valid4;
    logic [3:0] in_vec4;
    logic       cfg_busy4, cfg_done4, out_valid4, y4, loaded4;
    logic [4:0] ones4;

    // 6-input instance signals
    logic       cfg_start6, cfg_valid6, cfg_bit6, in_valid6;
    logic [5:0] in_vec6;
    logic       cfg_busy6, cfg_done6, out_valid6, y6, loaded6;
    logic [6:0] ones6;

    int n_checks = 0;
    int n_errors = 0;

    logic q4[$];
    logic q6[$];

    lut_expr_eval #(.N_IN(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(cfg_start4), .cfg_valid(cfg_valid4), .cfg_bit(cfg_bit4),
        .cfg_busy(cfg_busy4), .cfg_done(cfg_done4),
        .in_valid(in_valid4), .in_vec(in_vec4),
        .out_valid(out_valid4), .y(y4),
        .ones_count(ones4), .loaded(loaded4)
    );

    lut_expr_eval #(.N_IN(6)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(cfg_start6), .cfg_valid(cfg_valid6), .cfg_bit(cfg_bit6),
        .cfg_busy(cfg_busy6), .cfg_done(cfg_done6),
        .in_valid(in_valid6), .in_vec(in_vec6),
        .out_valid(out_valid6), .y(y6),
        .ones_count(ones6), .loaded(loaded6)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard monitors: every out_valid must match a queued expectation.
    always @(negedge clk) begin
        if (out_valid4) begin
            if (q4.size() == 0) check_val("ov4_unexpected", out_valid4, 0);
            else                check_val("y4", y4, q4.pop_front());
        end
    end

    always @(negedge clk) begin
        if (out_valid6) begin
            if (q6.size() == 0) check_val("ov6_unexpected", out_valid6, 0);
            else                check_val("y6", y6, q6.pop_front());
        end
    end

    // Stream 16 table bits into dut4, optionally with stall cycles and with
    // in_valid noise that must produce no output. The task is called just
    // after a negedge and returns just after the negedge that follows the
    // edge that writes the last entry.
    task automatic stream4(input logic [15:0] t, input logic [4:0] prev_ones,
                           input logic [4:0] exp_ones, input bit gaps, input bit noise);
        for (int i = 0; i < 16; i++) begin
            if (gaps && (i % 5 == 2)) begin
                cfg_valid4 = 1'b0;
                in_valid4  = noise;
                in_vec4    = 4'hF;
                @(negedge clk);
                check_val("busy4_gap", cfg_busy4, 1);
            end
            cfg_valid4 = 1'b1;
            cfg_bit4   = t[i];
            in_valid4  = noise;
            in_vec4    = 4'(i);
            @(negedge clk);
            if (i < 15) begin
                check_val("busy4", cfg_busy4, 1);
                check_val("done4_early", cfg_done4, 0);
                check_val("ones4_hold", ones4, prev_ones);
                check_val("loaded4_low", loaded4, 0);
            end
        end
        cfg_valid4 = 1'b0;
        in_valid4  = 1'b0;
        check_val("done4", cfg_done4, 1);
        check_val("ones4", ones4, exp_ones);
        check_val("loaded4", loaded4, 1);
        check_val("busy4_end", cfg_busy4, 0);
    endtask

    task automatic load4(input logic [15:0] t, input logic [4:0] prev_ones,
                         input logic [4:0] exp_ones, input bit gaps, input bit noise);
        cfg_start4 = 1'b1;
        @(negedge clk);
        cfg_start4 = 1'b0;
        check_val("busy4_start", cfg_busy4, 1);
        check_val("loaded4_start", loaded4, 0);
        stream4(t, prev_ones, exp_ones, gaps, noise);
    endtask

    // Back-to-back lookups on dut4; element i is vecs[4i+:4] -> exps[i].
    task automatic burst4(input logic [31:0] vecs, input logic [7:0] exps, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid4 = 1'b1;
            in_vec4   = vecs[i*4 +: 4];
            q4.push_back(exps[i]);
            @(negedge clk);
            check_val("ov4_stream", out_valid4, 1);
        end
        in_valid4 = 1'b0;
        @(negedge clk);
        check_val("ov4_drop", out_valid4, 0);
    endtask

    task automatic load6(input logic [63:0] t, input logic [6:0] exp_ones);
        cfg_start6 = 1'b1;
        @(negedge clk);
        cfg_start6 = 1'b0;
        check_val("busy6_start", cfg_busy6, 1);
        for (int i = 0; i < 64; i++) begin
            cfg_valid6 = 1'b1;
            cfg_bit6   = t[i];
            @(negedge clk);
            if (i < 63) check_val("done6_early", cfg_done6, 0);
        end
        cfg_valid6 = 1'b0;
        check_val("done6", cfg_done6, 1);
        check_val("ones6", ones6, exp_ones);
        check_val("loaded6", loaded6, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cfg_start4 = 0; cfg_valid4 = 0; cfg_bit4 = 0; in_valid4 = 0; in_vec4 = '0;
        cfg_start6 = 0; cfg_valid6 = 0; cfg_bit6 = 0; in_valid6 = 0; in_vec6 = '0;
        #1 rst_n = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_val("rst_y4", y4, 0);
        check_val("rst_ov4", out_valid4, 0);
        check_val("rst_busy4", cfg_busy4, 0);
        check_val("rst_done4", cfg_done4, 0);
        check_val("rst_ones4", ones4, 0);
        check_val("rst_loaded4", loaded4, 0);
        check_val("rst_ones6", ones6, 0);
        check_val("rst_loaded6", loaded6, 0);
        rst_n = 1'b1;

        // EMPTY: in_valid and cfg_valid are ignored
        cfg_valid4 = 1; cfg_bit4 = 1; in_valid4 = 1; in_vec4 = 4'hF;
        @(negedge clk);
        @(negedge clk);
        check_val("empty_ov4", out_valid4, 0);
        check_val("empty_busy4", cfg_busy4, 0);
        check_val("empty_ones4", ones4, 0);
        cfg_valid4 = 0; in_valid4 = 0;

        // Parity table 16'h6996, lookups start in the first RUN cycle
        load4(16'h6996, 5'd0, 5'd8, 1'b0, 1'b0);
        burst4({4'hA, 4'hF, 4'h7, 4'h0}, 8'b0000_0010, 4);

        // Legacy expression y=(a&b)|(c&~d): minterms 2,6,10,12,13,14,15
        load4(16'hF444, 5'd8, 5'd7, 1'b0, 1'b0);
        burst4({4'h2, 4'hE, 4'hD, 4'hA, 4'h7, 4'h0}, 8'b0011_1100, 6);

        // Stalled load with in_valid noise, then restart at idx 9 with cfg_valid high
        cfg_start4 = 1'b1;
        @(negedge clk);
        cfg_start4 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i % 3 == 1) begin
                cfg_valid4 = 1'b0;
                in_valid4  = 1'b1;
                @(negedge clk);
            end
            cfg_valid4 = 1'b1;
            cfg_bit4   = 1'b1;
            in_valid4  = 1'b1;
            in_vec4    = 4'h3;
            @(negedge clk);
            check_val("part_ones4_hold", ones4, 7);
            check_val("part_done4", cfg_done4, 0);
        end
        cfg_start4 = 1'b1;
        cfg_valid4 = 1'b1;
        cfg_bit4   = 1'b1;
        @(negedge clk);
        cfg_start4 = 1'b0;
        check_val("restart_busy4", cfg_busy4, 1);
        check_val("restart_ones4", ones4, 7);
        stream4(16'hA5F0, 5'd7, 5'd8, 1'b1, 1'b1);
        burst4({12'h0, 4'h9, 4'h8, 4'hF, 4'h3, 4'h4}, 8'b0000_1101, 5);

        // All-ones table: count reaches 16 without wrapping
        load4(16'hFFFF, 5'd8, 5'd16, 1'b0, 1'b0);
        burst4({4'h5, 4'h0}, 8'b0000_0011, 2);

        // Reset during evaluation: the in-flight lookup is dropped
        in_valid4 = 1'b1;
        in_vec4   = 4'hF;
        q4.push_back(1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_ov4", out_valid4, 0);
        check_val("mid_rst_y4", y4, 0);
        check_val("mid_rst_loaded4", loaded4, 0);
        check_val("mid_rst_ones4", ones4, 0);
        check_val("mid_rst_busy4", cfg_busy4, 0);
        @(negedge clk);
        check_val("mid_rst_ov4_hold", out_valid4, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_ov4", out_valid4, 0);
        check_val("post_rst_loaded4", loaded4, 0);
        in_valid4 = 1'b0;

        // All-zeros table
        load4(16'h0000, 5'd0, 5'd0, 1'b0, 1'b0);
        burst4({4'h0, 4'hF}, 8'b0000_0000, 2);

        // 6-input instance: only the top entry set
        load6(64'h8000_0000_0000_0000, 7'd1);
        in_valid6 = 1'b1;
        in_vec6   = 6'h3F;
        q6.push_back(1'b1);
        @(negedge clk);
        in_vec6   = 6'h3E;
        q6.push_back(1'b0);
        @(negedge clk);
        in_valid6 = 1'b0;
        @(negedge clk);
        check_val("ov6_drop", out_valid6, 0);

        @(negedge clk);
        check_val("q4_drained", 32'(q4.size()), 0);
        check_val("q6_drained", 32'(q6.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
